adder_layer_ctrl: RTL and testbench
===================================

ADDER_LAYER_CTRL -- requirements
Module: adder_layer_ctrl

Interface
REQ-001 Parameter RW, default 16: signed two's-complement width of the datapath result word.
REQ-002 Parameter ACCW, default 24: accumulator width (ACCW >= RW).
REQ-003 Parameter AW, default 8: tile-memory address width.
REQ-004 Parameter CW, default 8: tile-count width.
REQ-005 Port CLK  input  1  single clock; all state on rising edge.
REQ-006 Port RST  input  1  reset; asynchronous, active-high.
REQ-007 Port i_start  input  1  start request; sampled only in IDLE.
REQ-008 Port i_ntiles  input  CW  tiles per output; sampled with accepted start.
REQ-009 Port i_base  input  AW  first tile address; sampled with accepted start.
REQ-010 Port o_busy  output  1  high in every state except IDLE.
REQ-011 Port o_rd_en  output  1  tile-memory read strobe (ifmap and weight tiles read together).
REQ-012 Port o_rd_addr  output  AW  tile address for o_rd_en.
REQ-013 Port i_dp_result  input  RW  kernel/adder-tree result (registered datapath output).
REQ-014 Port o_acc  output  ACCW  accumulated result.
REQ-015 Port o_valid  output  1  o_acc valid.
REQ-016 Port i_ready  input  1  consumer accepts o_acc.
REQ-017 Port o_ovf  output  1  accumulator signed-overflow flag for current result.

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN, OUT; encoding free.
REQ-019 IDLE -> ISSUE when i_start=1 and i_ntiles!=0; i_start with i_ntiles=0 is ignored, no state change.
REQ-020 On accepted start: latch i_ntiles and i_base, clear accumulator, o_ovf, issue counter, in-flight tracker.
REQ-021 ISSUE: o_rd_en=1 every cycle for exactly N=latched ntiles consecutive cycles; o_rd_addr = base, base+1, ..., base+N-1, modulo 2^AW (wraps past all-ones to 0).
REQ-022 ISSUE -> DRAIN in the cycle after the Nth read; o_rd_en=0 outside ISSUE.
REQ-023 Fixed round-trip latency 3 cycles: result of read issued in cycle k is present on i_dp_result during cycle k+3 (1 memory + 2 datapath register stages); tracked by a 3-deep valid shift register.
REQ-024 i_dp_result is sampled only when the shift-register tail bit is 1; sign-extended to ACCW and added to accumulator.
REQ-025 Accumulator wraps modulo 2^ACCW; o_ovf set (sticky until next accepted start or reset) on any addition whose operand signs match and sum sign differs.
REQ-026 DRAIN -> OUT when the last in-flight result has been accumulated and tracker is empty.
REQ-027 Timing: start accepted at cycle 0 -> reads cycles 1..N -> last accumulate at cycle N+3 -> o_valid=1 from cycle N+4.
REQ-028 OUT: o_valid=1, o_acc stable; OUT -> IDLE on cycle with i_ready=1; holds indefinitely while i_ready=0.
REQ-029 o_valid=0 and o_acc holds last value outside OUT.
REQ-030 i_start in ISSUE, DRAIN or OUT is ignored; no queued start.
REQ-031 Start and i_ready in same cycle while in OUT: transfer completes, start ignored; new start needs IDLE.

Reset
REQ-032 RST=1 forces asynchronously: state IDLE, o_busy=0, o_rd_en=0, o_rd_addr=0, o_acc=0, o_valid=0, o_ovf=0, counters and valid tracker 0.
REQ-033 Reset mid-operation discards all in-flight results; first result after release comes only from a new start.

Verification
REQ-034 RW=16, ACCW=24: start N=4, base=0x10, dp_result 3,5,-2,7 -> rd_addr 0x10..0x13 cycles 1-4, o_valid cycle 8, o_acc=13, o_ovf=0.
REQ-035 N=1, i_ready held 0 for 5 cycles after o_valid -> o_valid and o_acc held 5 cycles, IDLE one cycle after i_ready=1.
REQ-036 base=0xFE, N=3 -> rd_addr 0xFE, 0xFF, 0x00.
REQ-037 i_start with i_ntiles=0 -> o_busy stays 0, no o_rd_en; i_start pulses during ISSUE/OUT -> no effect on count or o_acc.
REQ-038 ACCW=16, N=2, results 0x7FFF, 1 -> o_acc=0x8000, o_ovf=1; next start clears o_ovf.
REQ-039 RST asserted at cycle 2 of N=8 run -> all outputs 0 immediately; restart N=2 yields only new two results.

Source files
------------

// File: rtl/adder_layer_ctrl.sv
// Tile-read sequencer and result accumulator for one adder-layer output word.
// Issues N tile reads, accumulates the datapath results 3 cycles later, then hands off o_acc.
module adder_layer_ctrl #(
  parameter int unsigned RW   = 16,
  parameter int unsigned ACCW = 24,
  parameter int unsigned AW   = 8,
  parameter int unsigned CW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_start,
  input  logic [CW-1:0]   i_ntiles,
  input  logic [AW-1:0]   i_base,
  output logic            o_busy,
  output logic            o_rd_en,
  output logic [AW-1:0]   o_rd_addr,
  input  logic [RW-1:0]   i_dp_result,
  output logic [ACCW-1:0] o_acc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_ovf
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ntiles_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      vld_q;
  logic [ACCW-1:0] acc_q;
  logic            ovf_q;

  logic            start_ok;
  logic            rd_en;
  logic [ACCW-1:0] dp_ext;
  logic [ACCW-1:0] sum;
  logic            ovf_step;

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start && (i_ntiles != '0)) begin
          state_d  = StIssue;
          start_ok = 1'b1;
        end
      end
      StIssue: begin
        if (cnt_q == ntiles_q - CW'(1)) state_d = StDrain;
      end
      StDrain: begin
        // Last result is at the tail with nothing still in flight behind it.
        if (vld_q == 3'b100) state_d = StOut;
      end
      StOut: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_en    = (state_q == StIssue);
  assign dp_ext   = ACCW'($signed(i_dp_result));
  assign sum      = acc_q + dp_ext;
  assign ovf_step = (acc_q[ACCW-1] == dp_ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      ntiles_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      vld_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        ntiles_q <= i_ntiles;
        addr_q   <= i_base;
        cnt_q    <= '0;
        vld_q    <= '0;
        acc_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        vld_q <= {vld_q[1:0], rd_en};
        if (rd_en) begin
          addr_q <= addr_q + AW'(1);
          cnt_q  <= cnt_q + CW'(1);
        end
        if (vld_q[2]) begin
          acc_q <= sum;
          if (ovf_step) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = (state_q != StIdle);
  assign o_rd_en   = rd_en;
  assign o_rd_addr = addr_q;
  assign o_acc     = acc_q;
  assign o_valid   = (state_q == StOut);
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_adder_layer_ctrl.sv
// Bench for adder_layer_ctrl: a 24-bit and a 16-bit accumulator instance share stimulus and
// an emulated 3-cycle tile memory/datapath; checked against table constants and a model.
module tb_adder_layer_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_ntiles = '0;
  logic [7:0]  i_base = '0;
  logic        i_ready = 1'b0;
  logic [15:0] dp_result;

  logic        busy, rd_en, valid, ovf;
  logic [7:0]  rd_addr;
  logic [23:0] acc;
  logic        busy16, rd_en16, valid16, ovf16;
  logic [7:0]  rd_addr16;
  logic [15:0] acc16;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  adder_layer_ctrl #(.RW(16), .ACCW(24), .AW(8), .CW(8)) u_dut (
    .CLK(CLK), .RST(RST), .i_start(i_start), .i_ntiles(i_ntiles), .i_base(i_base),
    .o_busy(busy), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_dp_result(dp_result),
    .o_acc(acc), .o_valid(valid), .i_ready(i_ready), .o_ovf(ovf)
  );

  adder_layer_ctrl #(.RW(16), .ACCW(16), .AW(8), .CW(8)) u_dut16 (
    .CLK(CLK), .RST(RST), .i_start(i_start), .i_ntiles(i_ntiles), .i_base(i_base),
    .o_busy(busy16), .o_rd_en(rd_en16), .o_rd_addr(rd_addr16), .i_dp_result(dp_result),
    .o_acc(acc16), .o_valid(valid16), .i_ready(i_ready), .o_ovf(ovf16)
  );

  // Tile memory plus two datapath stages; random junk whenever no result is due.
  logic [15:0] mem [256];
  logic [2:0]  p_vld = '0;
  logic [15:0] p_dat [3];
  logic [15:0] junk = '0;

  always @(posedge CLK) begin
    p_vld    <= {p_vld[1:0], rd_en};
    p_dat[0] <= mem[rd_addr];
    p_dat[1] <= p_dat[0];
    p_dat[2] <= p_dat[1];
    junk     <= 16'($urandom);
  end

  assign dp_result = p_vld[2] ? p_dat[2] : junk;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Signed sum of the N tile results, wrapped to w bits, with sticky signed-overflow.
  function automatic void model(input int n, input int base, input int w,
                                output longint acc_o, output bit ovf_o);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    longint s;
    longint a = 0;
    ovf_o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = a + longint'($signed(mem[(base + i) % 256]));
      if (s > hi || s < lo) begin
        ovf_o = 1'b1;
        s = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
      end
      a = s;
    end
    acc_o = a & ((longint'(1) << w) - 1);
  endfunction

  // Called at a negedge: that cycle is cycle 0 (start presented).
  task automatic run_txn(input int n, input int base, input int hold, input bit poke,
                         input longint e24, input bit o24, input longint e16, input bit o16);
    i_start  = 1'b1;
    i_ntiles = 8'(n);
    i_base   = 8'(base);
    for (int j = 1; j <= n + 4 + hold; j++) begin
      @(negedge CLK);
      if (j == 1) begin
        if (poke) begin
          i_ntiles = 8'd5;
          i_base   = 8'(base) ^ 8'h55;
        end else begin
          i_start = 1'b0;
        end
      end
      chk("rd_en", longint'(rd_en), longint'(j <= n));
      chk("rd_en16", longint'(rd_en16), longint'(j <= n));
      if (j <= n) chk("rd_addr", longint'(rd_addr), longint'((base + j - 1) % 256));
      chk("busy", longint'(busy), 1);
      chk("valid", longint'(valid), longint'(j >= n + 4));
      chk("valid16", longint'(valid16), longint'(j >= n + 4));
      if (j >= n + 4) begin
        chk("acc24", longint'(acc), e24);
        chk("ovf24", longint'(ovf), longint'(o24));
        chk("acc16", longint'(acc16), e16);
        chk("ovf16", longint'(ovf16), longint'(o16));
      end
      if (j == n + 4 + hold) i_ready = 1'b1;
    end
    @(negedge CLK);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_valid", longint'(valid), 0);
    i_ready = 1'b0;
    i_start = 1'b0;
  endtask

  typedef struct packed {
    int               n;
    logic [7:0]       base;
    int               hold;
    bit               poke;
    logic [3:0][15:0] v;
    logic [23:0]      acc24;
    bit               ovf24;
    logic [15:0]      acc16;
    bit               ovf16;
  } vec_t;

  vec_t tbl [7];

  initial begin
    longint e24, e16;
    bit     o24, o16;
    int     n, base;

    tbl[0] = '{4, 8'h10, 0, 1'b0, {16'h0007, 16'hFFFE, 16'h0005, 16'h0003},
               24'd13, 1'b0, 16'd13, 1'b0};
    tbl[1] = '{1, 8'h20, 5, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'hFFF7},
               24'hFFFFF7, 1'b0, 16'hFFF7, 1'b0};
    tbl[2] = '{3, 8'hFE, 1, 1'b0, {16'h0000, 16'd300, 16'd200, 16'd100},
               24'd600, 1'b0, 16'd600, 1'b0};
    tbl[3] = '{2, 8'h40, 0, 1'b0, {16'h0000, 16'h0000, 16'h0001, 16'h7FFF},
               24'h008000, 1'b0, 16'h8000, 1'b1};
    tbl[4] = '{2, 8'h50, 2, 1'b1, {16'h0000, 16'h0000, 16'h0002, 16'h0001},
               24'd3, 1'b0, 16'd3, 1'b0};
    tbl[5] = '{2, 8'h60, 0, 1'b0, {16'h0000, 16'h0000, 16'hFFFF, 16'h8000},
               24'hFF7FFF, 1'b0, 16'h7FFF, 1'b1};
    tbl[6] = '{3, 8'h70, 0, 1'b1, {16'h0000, 16'h1000, 16'h0001, 16'h7FFF},
               24'h009000, 1'b0, 16'h9000, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_rd_en", longint'(rd_en), 0);
    chk("rst_rd_addr", longint'(rd_addr), 0);
    chk("rst_acc", longint'(acc), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_ovf", longint'(ovf), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Zero-tile start is ignored
    i_start  = 1'b1;
    i_ntiles = 8'd0;
    i_base   = 8'h33;
    repeat (3) begin
      @(negedge CLK);
      chk("zero_busy", longint'(busy), 0);
      chk("zero_rd_en", longint'(rd_en), 0);
    end
    i_start = 1'b0;
    @(negedge CLK);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < tbl[t].n; i++) mem[(int'(tbl[t].base) + i) % 256] = tbl[t].v[i];
      run_txn(tbl[t].n, int'(tbl[t].base), tbl[t].hold, tbl[t].poke,
              longint'(tbl[t].acc24), tbl[t].ovf24, longint'(tbl[t].acc16), tbl[t].ovf16);
    end

    // Reset in cycle 2 of an 8-tile run, then restart straight away
    i_start  = 1'b1;
    i_ntiles = 8'd8;
    i_base   = 8'h80;
    @(negedge CLK);
    i_start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_rd_en", longint'(rd_en), 0);
    chk("mid_rst_rd_addr", longint'(rd_addr), 0);
    chk("mid_rst_acc", longint'(acc), 0);
    chk("mid_rst_valid", longint'(valid), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    @(negedge CLK);
    RST = 1'b0;
    mem[8'h90] = 16'd11;
    mem[8'h91] = 16'hFFFB;
    model(2, 8'h90, 24, e24, o24);
    model(2, 8'h90, 16, e16, o16);
    run_txn(2, 8'h90, 1, 1'b0, e24, o24, e16, o16);

    // Randomised transactions against the model
    for (int t = 0; t < 30; t++) begin
      n    = $urandom_range(1, 20);
      base = $urandom_range(0, 255);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0:       mem[(base + i) % 256] = 16'($urandom_range(0, 200) - 100);
          1:       mem[(base + i) % 256] = 16'h7F00 + 16'($urandom_range(0, 255));
          default: mem[(base + i) % 256] = 16'h8000 + 16'($urandom_range(0, 255));
        endcase
      end
      model(n, base, 24, e24, o24);
      model(n, base, 16, e16, o16);
      run_txn(n, base, $urandom_range(0, 3), 1'($urandom_range(0, 1)), e24, o24, e16, o16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
